// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_bank data memory.
// Optional parity storage is enabled with DMEM_PARITY_EN.
package dmem_pkg;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;
    localparam int PAR_MAX_W  = 64;

    // Even parity bit: zero-extension of narrower words leaves it unchanged.
    function automatic logic par_even(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port-write, registered-read RAM without reset (maps to block RAM).
// Width includes the parity bit when DMEM_PARITY_EN is defined in the parent.
module dmem_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata_q
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_bank.sv
// Parametrised data memory bank: init FSM, valid/ready port, pipelined reads.
// Define DMEM_PARITY_EN to store an even-parity bit per word (adds inj_par_err).
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_PARITY_EN
    input  logic              inj_par_err,
`endif
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              wr_err,
    output logic              busy
);

    localparam int CW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT = (RD_LAT >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;
`ifdef DMEM_PARITY_EN
    localparam int MW  = DATA_W + 1;
`else
    localparam int MW  = DATA_W;
`endif
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t          state_q, state_d;
    logic [CW-1:0]   init_cnt_q, init_cnt_d;
    logic            wr_err_q, wr_err_d;
    logic            v1_q, v1_d;
    logic            oor1_q, oor1_d;

    logic            accept;
    logic            in_range;
    logic            arr_we;
    logic [CW-1:0]   arr_waddr;
    logic [DATA_W-1:0] wr_data_raw;
    logic [MW-1:0]   arr_wdata;
    logic            arr_re;
    logic [MW-1:0]   arr_rdata;
    logic [DATA_W-1:0] s1_data;
    logic            s1_err;
`ifdef DMEM_PARITY_EN
    logic            par_flip;
`endif

    assign req_ready = (state_q == ST_READY);
    assign busy      = (state_q == ST_INIT);
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < DEPTH_L;
    assign arr_re    = accept && !req_we;
    assign wr_err    = wr_err_q;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        arr_we      = 1'b0;
        arr_waddr   = init_cnt_q;
        wr_data_raw = DATA_W'(init_cnt_q);
`ifdef DMEM_PARITY_EN
        par_flip    = 1'b0;
`endif
        unique case (1'b1)
            (state_q == ST_INIT): begin
                arr_we     = 1'b1;
                init_cnt_d = init_cnt_q + CW'(1);
                if (init_cnt_q == CW'(DEPTH - 1)) begin
                    state_d    = ST_READY;
                    init_cnt_d = '0;
                end
            end
            (state_q == ST_READY): begin
                if (accept && req_we && in_range) begin
                    arr_we      = 1'b1;
                    arr_waddr   = req_addr[CW-1:0];
                    wr_data_raw = req_wdata;
`ifdef DMEM_PARITY_EN
                    par_flip    = inj_par_err;
`endif
                end
            end
        endcase
    end

`ifdef DMEM_PARITY_EN
    assign arr_wdata = {par_even(PAR_MAX_W'(wr_data_raw)) ^ par_flip,
                        wr_data_raw};
`else
    assign arr_wdata = wr_data_raw;
`endif

    always_comb begin
        v1_d     = accept && !req_we;
        oor1_d   = accept && !req_we && !in_range;
        wr_err_d = accept && req_we && !in_range;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            wr_err_q   <= 1'b0;
            v1_q       <= 1'b0;
            oor1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wr_err_q   <= wr_err_d;
            v1_q       <= v1_d;
            oor1_q     <= oor1_d;
        end
    end

    dmem_array #(
        .WIDTH (MW),
        .DEPTH (DEPTH),
        .AW    (CW)
    ) u_array (
        .clk     (clk),
        .we      (arr_we),
        .waddr   (arr_waddr),
        .wdata   (arr_wdata),
        .re      (arr_re),
        .raddr   (req_addr[CW-1:0]),
        .rdata_q (arr_rdata)
    );

    // Out-of-range reads return zero; the RAM output is don't-care there.
    assign s1_data = oor1_q ? '0 : arr_rdata[DATA_W-1:0];
`ifdef DMEM_PARITY_EN
    assign s1_err  = oor1_q ||
        (arr_rdata[DATA_W] != par_even(PAR_MAX_W'(arr_rdata[DATA_W-1:0])));
`else
    assign s1_err  = oor1_q;
`endif

    if (LAT == RD_LAT_MIN) begin : g_lat1
        logic [DATA_W-1:0] hold_q, hold_d;

        assign hold_d = v1_q ? s1_data : hold_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hold_q <= '0;
            end else begin
                hold_q <= hold_d;
            end
        end

        assign resp_valid = v1_q;
        assign resp_rdata = hold_d;
        assign resp_err   = v1_q && s1_err;
    end else begin : g_lat2
        logic              v2_q, v2_d;
        logic              err2_q, err2_d;
        logic [DATA_W-1:0] rdata2_q, rdata2_d;

        always_comb begin
            v2_d     = v1_q;
            err2_d   = v1_q && s1_err;
            rdata2_d = v1_q ? s1_data : rdata2_q;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                v2_q     <= 1'b0;
                err2_q   <= 1'b0;
                rdata2_q <= '0;
            end else begin
                v2_q     <= v2_d;
                err2_q   <= err2_d;
                rdata2_q <= rdata2_d;
            end
        end

        assign resp_valid = v2_q;
        assign resp_rdata = rdata2_q;
        assign resp_err   = err2_q;
    end

endmodule

// File: doc/dmem_bank.md
Name: dmem_bank

Overview:
- Parametrised successor of the 8x8 data memory; sits between the load/store unit and the register file write-back path.
- Adds configurable width/depth and a valid/ready request port.
- Adds a pipelined read response with configurable latency and out-of-range error reporting.
- Reset-time preload (word i = i) moves from a flat async-reset assignment to a sequenced init state machine.

Parameters:
- DATA_W, 8, data word width in bits (>=4).
- ADDR_W, 8, request address width.
- DEPTH, 16, number of words; must satisfy DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles from request acceptance to resp_valid; legal values 1 or 2.

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bank can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  read data valid (one-cycle pulse per read)
- resp_rdata  out  DATA_W  read data
- resp_err  out  1  qualifies resp_valid: address out of range (or parity fail, see feature)
- wr_err  out  1  one-cycle pulse: rejected out-of-range write
- busy  out  1  high while the init sequence runs

Behaviour:
- Reset values (reset=0, asynchronous):
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, wr_err=0, busy=1.
  - State=INIT, init_cnt=0, read pipeline valid bits cleared.
  - Array contents are not reset directly.
- States:
  - INIT: each cycle writes mem[init_cnt] = init_cnt[DATA_W-1:0], then increments init_cnt. At init_cnt==DEPTH-1 the write occurs and the next state is READY. INIT lasts exactly DEPTH cycles after reset deassertion. busy=1, req_ready=0; req_valid is ignored.
  - READY: req_ready=1, busy=0. Remains in READY until reset.
- Accept condition: req_valid && req_ready. One request per cycle, no stalls in READY.
- Write, addr < DEPTH: mem[addr] <= req_wdata at the accepting edge. No response is generated.
- Write, addr >= DEPTH: array unchanged; wr_err=1 for the following cycle.
- Read, addr < DEPTH:
  - RD_LAT=1: resp_valid=1 in the cycle after acceptance, with rdata = mem[addr].
  - RD_LAT=2: resp_valid=1 one cycle later; the second stage is an output register.
- Read, addr >= DEPTH: resp_valid pulses with the same latency, resp_rdata=0, resp_err=1.
- Back-to-back reads give back-to-back resp_valid pulses, in order. There is no response backpressure.
- Write followed by a read of the same address in the next cycle returns the new data.
- When resp_valid=0, resp_rdata holds its last value and resp_err=0.
- Reset asserted mid-operation: in-flight reads are dropped (no resp_valid) and the bank re-enters INIT, reloading the full preload pattern.
- init_cnt width: $clog2(DEPTH), with a minimum of 1.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on every write including init.
  - On read, a stored-parity mismatch sets resp_err=1 alongside valid resp_rdata (raw data is still returned).
  - Adds input inj_par_err (1 bit): when high during an accepted write, the stored parity bit is inverted.
- Undefined: no parity storage, no inj_par_err port; resp_err reflects out-of-range only.

Decomposition:
- Package dmem_pkg:
  - state enum {ST_INIT, ST_READY}
  - constants RD_LAT_MIN=1, RD_LAT_MAX=2
  - function par_even(data)
- Sub-module dmem_array: plain synchronous RAM with one write port and one registered read port, width DATA_W (+1 with parity). It has no reset, so it stays synthesisable as block RAM.
- dmem_bank holds the FSM, init counter, range check, latency pipeline and error logic.

Test Plan:
- Init: release reset with DEPTH=16 → busy=1 and req_ready=0 for exactly 16 cycles. Then read addr 0..15 → resp_rdata equals 0x00..0x0F, with resp_valid exactly RD_LAT cycles after each accept.
- Write/read: write 0xA5 to addr 3, then read addr 3 in the next cycle → resp_rdata=0xA5 and resp_err=0. A read of addr 4 in the following cycle → 0x04.
- Out of range: write 0x55 to addr 20 → wr_err pulses one cycle. Read addr 20 → resp_rdata=0x00 and resp_err=1. Read addr 15 → 0x0F (contents unchanged).
- Streaming: reads of addrs 1,2,3 on consecutive cycles with RD_LAT=2 → three consecutive resp_valid pulses with data 1,2,3, in order.
- Reset mid-flight: write 0xFF to addr 5, issue a read of addr 5, assert reset in the next cycle → no resp_valid. After the init sequence, a read of addr 5 returns 0x05.
- DMEM_PARITY_EN defined: write 0x3C with inj_par_err=1, then read the same address → resp_rdata=0x3C and resp_err=1. Rewrite with inj_par_err=0 → resp_err=0.
